// File: rtl/eth_rx_framer.sv
// rtl/eth_rx_framer.sv - Ethernet receive framer: preamble/SFD detect, FCS strip, frame verdict
// Optional CRC-32 check is built only when ETH_RX_FRAMER_CRC_EN is defined.
module eth_rx_framer #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic       rx_error,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       out_good
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
    localparam logic [15:0] FCS_DEPTH = 16'd5;

    state_t           state_q;
    logic [4:0][7:0]  dly_q;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic             err_q;
    logic             crc_ok;
    logic             len_ok;
    logic             have_payload;

    // Byte counter saturates so oversize frames cannot wrap back into the legal range.
    assign cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign len_ok       = (cnt_q >= MIN_LEN_C) && (cnt_q <= MAX_LEN_C);
    assign have_payload = (cnt_q >= FCS_DEPTH);

`ifdef ETH_RX_FRAMER_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Next CRC value for the byte currently on rx_data.
    always_comb begin
        crc_d = crc32_byte(crc_q, rx_data);
    end

    // CRC is held at its seed outside DATA so it is fresh on every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (state_q != S_DATA) begin
            crc_q <= 32'hFFFFFFFF;
        end else if (rx_valid) begin
            crc_q <= crc_d;
        end
    end

    // Running CRC over data plus FCS lands on the fixed residue for an intact frame.
    assign crc_ok = (crc_q == 32'hDEBB20E3);
`else
    assign crc_ok = 1'b1;
`endif

    // Framing FSM with registered outputs; the 5-byte delay line hides the trailing FCS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dly_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_good  <= 1'b0;

            if (state_q != S_DATA) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == PRE_BYTE) begin
                            state_q <= S_PREAMBLE;
                        end else if (rx_data == SFD_BYTE) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end
                end

                S_PREAMBLE: begin
                    if (!rx_valid) begin
                        state_q <= S_IDLE;
                    end else if (rx_data == SFD_BYTE) begin
                        state_q <= S_DATA;
                    end else if (rx_data != PRE_BYTE) begin
                        state_q <= S_DROP;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        dly_q <= {dly_q[3:0], rx_data};
                        cnt_q <= cnt_d;
                        err_q <= err_q | rx_error;
                        if (have_payload) begin
                            out_valid <= 1'b1;
                            out_data  <= dly_q[4];
                            out_sof   <= (cnt_q == FCS_DEPTH);
                        end
                    end else begin
                        state_q <= S_IDLE;
                        if (have_payload) begin
                            out_valid <= 1'b1;
                            out_data  <= dly_q[4];
                            out_sof   <= (cnt_q == FCS_DEPTH);
                            out_eof   <= 1'b1;
                            out_good  <= crc_ok && !err_q && len_ok;
                        end
                    end
                end

                S_DROP: begin
                    if (!rx_valid) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb/tb_eth_rx_framer.sv - scoreboard bench for eth_rx_framer
module tb_eth_rx_framer;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        logic       good;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] rx_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       out_good;

    int         total;
    int         bad;
    int         cyc;
    int         eof_cyc;
    int         end_cyc;
    exp_t       sbq[$];
    logic [7:0] pay[$];

    eth_rx_framer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_error  (rx_error),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_good  (out_good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic fill_pay(input int n, input int base);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(base + i));
    endtask

    // Pops one expectation per out_valid cycle and checks it.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: data=%h sof=%b eof=%b, none expected", out_data, out_sof, out_eof);
                end else begin
                    e = sbq.pop_front();
                    if (out_data !== e.d || out_sof !== e.sof || out_eof !== e.eof) begin
                        bad++;
                        $display("FAIL out_byte: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b",
                                 out_data, out_sof, out_eof, e.d, e.sof, e.eof);
                    end
                    if (e.eof) begin
                        eof_cyc = cyc;
                        total++;
                        if (out_good !== e.good) begin
                            bad++;
                            $display("FAIL out_good: got %b, want %b", out_good, e.good);
                        end
                    end
                end
            end
        end
    endtask

    // Sends preamble/SFD, global payload and FCS, then one idle cycle; queues the expected bytes.
    task automatic send_frame(input int npre, input bit flip_fcs, input int err_at, input bit bad_first);
        logic [31:0] c;
        logic [7:0]  fcs[4];
        int          n;
        bit          g;
        exp_t        e;
        n = pay.size();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_step(c, pay[i]);
        c = ~c;
        fcs[0] = c[7:0];
        fcs[1] = c[15:8];
        fcs[2] = c[23:16];
        fcs[3] = c[31:24];
        if (flip_fcs) fcs[0][0] = ~fcs[0][0];
        g = (err_at < 0) && (n + 4 >= 64) && (n + 4 <= 1518);
`ifdef ETH_RX_FRAMER_CRC_EN
        if (flip_fcs) g = 1'b0;
`endif
        if (!bad_first) begin
            for (int i = 0; i < n; i++) begin
                e.d    = pay[i];
                e.sof  = (i == 0);
                e.eof  = (i == n - 1);
                e.good = (i == n - 1) ? g : 1'b0;
                sbq.push_back(e);
            end
        end
        eof_cyc = -1;
        if (bad_first) drive(1'b1, 1'b0, 8'h00);
        repeat (npre) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < n; i++) drive(1'b1, (i == err_at), pay[i]);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, fcs[i]);
        drive(1'b0, 1'b0, 8'h00);
        end_cyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        total++;
        if ({out_valid, out_sof, out_eof, out_good, out_data} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b sof=%b eof=%b good=%b d=%h, want all 0",
                     out_valid, out_sof, out_eof, out_good, out_data);
        end
        rst_n = 1'b1;
        idle(2);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_good_frame();
        fill_pay(60, 0);
        send_frame(7, 1'b0, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL good_drain: %0d bytes missing, want 0", sbq.size());
        end
        total++;
        if (eof_cyc != end_cyc) begin
            bad++;
            $display("FAIL good_eof_timing: eof at cycle %0d, want %0d", eof_cyc, end_cyc);
        end
    endtask

    task automatic test_bad_fcs();
        fill_pay(60, 0);
        send_frame(7, 1'b1, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL bad_fcs_drain: %0d bytes missing, want 0", sbq.size());
        end
    endtask

    task automatic test_rx_error();
        fill_pay(60, 0);
        send_frame(7, 1'b0, 20, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL rx_error_drain: %0d bytes missing, want 0", sbq.size());
        end
    endtask

    task automatic test_runt();
        for (int k = 3; k <= 4; k++) begin
            repeat (7) drive(1'b1, 1'b0, 8'h55);
            drive(1'b1, 1'b0, 8'hD5);
            for (int i = 0; i < k; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i));
            idle(4);
        end
        fill_pay(1, 8'h77);
        send_frame(7, 1'b0, -1, 1'b0);
        idle(4);
        fill_pay(41, 8'h10);
        send_frame(7, 1'b0, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL runt_drain: %0d bytes missing, want 0", sbq.size());
        end
    endtask

    task automatic test_length_bounds();
        int lens[4];
        lens = '{59, 60, 1514, 1515};
        for (int j = 0; j < 4; j++) begin
            fill_pay(lens[j], j * 3);
            send_frame(2, 1'b0, -1, 1'b0);
            idle(3);
            total++;
            if (sbq.size() != 0 || eof_cyc != end_cyc) begin
                bad++;
                $display("FAIL length_%0d: missing=%0d eof_cyc=%0d, want 0 and %0d",
                         lens[j], sbq.size(), eof_cyc, end_cyc);
            end
        end
    endtask

    task automatic test_bad_preamble();
        fill_pay(60, 0);
        send_frame(7, 1'b0, -1, 1'b1);
        fill_pay(64, 8'h40);
        send_frame(7, 1'b0, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL bad_preamble_recover: %0d bytes missing, want 0", sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        fill_pay(70, 8'h20);
        send_frame(0, 1'b0, -1, 1'b0);
        fill_pay(62, 8'h90);
        send_frame(0, 1'b0, -1, 1'b0);
        fill_pay(60, 8'h05);
        send_frame(7, 1'b1, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL back_to_back_drain: %0d bytes missing, want 0", sbq.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        fill_pay(60, 0);
        for (int i = 0; i < 25; i++) begin
            e.d    = 8'(i);
            e.sof  = (i == 0);
            e.eof  = 1'b0;
            e.good = 1'b0;
            sbq.push_back(e);
        end
        repeat (7) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i <= 30; i++) drive(1'b1, 1'b0, pay[i]);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd25) begin
            bad++;
            $display("FAIL pre_reset_byte: got v=%b d=%h, want v=1 d=19", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_sof, out_eof, out_good} !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_clear: got v=%b sof=%b eof=%b good=%b, want 0",
                     out_valid, out_sof, out_eof, out_good);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 31; i < 60; i++) drive(1'b1, 1'b0, pay[i]);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i));
        idle(4);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_frame_drain: %0d bytes missing, want 0", sbq.size());
        end
        fill_pay(60, 8'h30);
        send_frame(7, 1'b0, -1, 1'b0);
        idle(4);
        total++;
        if (sbq.size() != 0 || eof_cyc != end_cyc) begin
            bad++;
            $display("FAIL after_reset_frame: missing=%0d eof_cyc=%0d, want 0 and %0d",
                     sbq.size(), eof_cyc, end_cyc);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        eof_cyc  = -1;
        end_cyc  = 0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
        fork
            monitor();
        join_none
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_rx_error();
        test_runt();
        test_length_bounds();
        test_bad_preamble();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
